// File: rtl/painterengine_gpu_reader.sv
// painterengine_gpu_reader: AXI4 INCR burst read master that streams `length`
// 32-bit pixels from `address` into the downstream pixel FIFO. Each job is cut
// into bursts of at most MAX_BURST beats, and the block reports done or error.
// Timing: arvalid rises two cycles after enable. done/error are registered and
// rise one cycle after the FSM reaches DONE/ERROR. The FIFO write strobe is the
// combinational rvalid&rready.
// Backpressure: rready = !fifo_full, so the FIFO is never written while full.
// Optional build macro PAINTERENGINE_GPU_READER_4K_SPLIT_EN also caps each
// burst at the next 4 KB boundary.
// Ports: i_wire_clock / i_wire_resetn (async, active-low); job interface
// (enable, address, length, done, error); AXI AR and R channels; FIFO write
// side (wdata, wen, full); o_wire_state = {24'd0, state code}.
module painterengine_gpu_reader #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic        i_wire_enable,
  input  logic [31:0] i_wire_address,
  input  logic [31:0] i_wire_length,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [31:0] o_wire_araddr,
  output logic [7:0]  o_wire_arlen,
  output logic [2:0]  o_wire_arsize,
  output logic [1:0]  o_wire_arburst,
  output logic        o_wire_arvalid,
  input  logic        i_wire_arready,
  input  logic [31:0] i_wire_rdata,
  input  logic [1:0]  i_wire_rresp,
  input  logic        i_wire_rlast,
  input  logic        i_wire_rvalid,
  output logic        o_wire_rready,
  output logic [31:0] o_wire_fifo_wdata,
  output logic        o_wire_fifo_wen,
  input  logic        i_wire_fifo_full,
  output logic [31:0] o_wire_state
);

  typedef enum logic [7:0] {
    ST_IDLE  = 8'h00,
    ST_CALC  = 8'h01,
    ST_ADDR  = 8'h02,
    ST_DATA  = 8'h03,
    ST_DONE  = 8'h04,
    ST_ERROR = 8'h05,
    ST_ABORT = 8'h06
  } state_t;

  localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);

  state_t      state_q, state_d;
  logic [31:0] cur_addr;
  logic [31:0] remaining;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [8:0]  beat_cnt;
  logic        err_q;
  logic        ar_done;   // address of the current burst has been accepted
  logic        done_q;
  logic        error_q;

  logic [31:0] burst_words;
  logic [31:0] beats_now;
  logic        beat_acc;
  logic        last_beat;
  logic        beat_bad;
  logic        burst_err;

`ifdef PAINTERENGINE_GPU_READER_4K_SPLIT_EN
  logic [12:0] bytes_to_4k;
  logic [31:0] words_to_4k;
`endif

  // Burst sizing for the next request.
  always_comb begin
    burst_words = (remaining < MAX_BURST_W) ? remaining : MAX_BURST_W;
`ifdef PAINTERENGINE_GPU_READER_4K_SPLIT_EN
    bytes_to_4k = 13'd4096 - {1'b0, cur_addr[11:0]};
    words_to_4k = {19'd0, bytes_to_4k} >> 2;
    if (words_to_4k < burst_words) burst_words = words_to_4k;
`endif
  end

  assign beats_now = {24'd0, arlen_q} + 32'd1;
  assign beat_acc  = i_wire_rvalid & o_wire_rready;
  assign last_beat = beat_acc & i_wire_rlast;
  // A beat is bad if it carries an error response, or if rlast does not line
  // up with the expected final beat (early rlast, missing rlast, extra beats).
  assign beat_bad  = beat_acc & ((i_wire_rresp != 2'b00) |
                                 (i_wire_rlast != (beat_cnt == {1'b0, arlen_q})));
  assign burst_err = err_q | beat_bad;

  // State register.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_wire_enable) begin
          if (i_wire_length == 32'd0)          state_d = ST_DONE;
          else if (i_wire_address[1:0] != 2'b00) state_d = ST_ERROR;
          else                                 state_d = ST_CALC;
        end
      end
      ST_CALC: state_d = i_wire_enable ? ST_ADDR : ST_IDLE;
      ST_ADDR: begin
        if (!i_wire_enable)      state_d = ST_ABORT;
        else if (i_wire_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (last_beat) begin
          // Burst finished in the same cycle enable dropped: nothing to drain.
          if (!i_wire_enable)          state_d = ST_IDLE;
          else if (burst_err)          state_d = ST_ERROR;
          else if (remaining == beats_now) state_d = ST_DONE;
          else                         state_d = ST_CALC;
        end else if (!i_wire_enable) begin
          state_d = ST_ABORT;
        end
      end
      ST_DONE:  if (!i_wire_enable) state_d = ST_IDLE;
      ST_ERROR: if (!i_wire_enable) state_d = ST_IDLE;
      ST_ABORT: if (last_beat)      state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    o_wire_arvalid  = 1'b0;
    o_wire_rready   = 1'b0;
    o_wire_fifo_wen = 1'b0;
    case (state_q)
      ST_ADDR: o_wire_arvalid = 1'b1;
      ST_DATA: begin
        o_wire_rready   = !i_wire_fifo_full;
        o_wire_fifo_wen = i_wire_rvalid & !i_wire_fifo_full;
      end
      ST_ABORT: begin
        // Finish an outstanding address handshake, then sink the data.
        o_wire_arvalid = !ar_done;
        o_wire_rready  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_wire_araddr     = araddr_q;
  assign o_wire_arlen      = arlen_q;
  assign o_wire_arsize     = 3'b010;
  assign o_wire_arburst    = 2'b01;
  assign o_wire_fifo_wdata = i_wire_rdata;
  assign o_wire_done       = done_q;
  assign o_wire_error      = error_q;
  assign o_wire_state      = {24'd0, state_q};

  // Job datapath.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      cur_addr  <= 32'd0;
      remaining <= 32'd0;
      araddr_q  <= 32'd0;
      arlen_q   <= 8'd0;
      beat_cnt  <= 9'd0;
      err_q     <= 1'b0;
      ar_done   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= (state_q == ST_DONE)  & i_wire_enable;
      error_q <= (state_q == ST_ERROR) & i_wire_enable;

      if (o_wire_arvalid & i_wire_arready) ar_done <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          err_q <= 1'b0;
          if (i_wire_enable) begin
            cur_addr  <= i_wire_address;
            remaining <= i_wire_length;
          end
        end
        ST_CALC: begin
          araddr_q <= cur_addr;
          arlen_q  <= 8'(burst_words - 32'd1);
          beat_cnt <= 9'd0;
          err_q    <= 1'b0;
          ar_done  <= 1'b0;
        end
        ST_DATA: begin
          if (beat_acc) begin
            if (beat_cnt != 9'h1ff) beat_cnt <= beat_cnt + 9'd1;
            if (beat_bad) err_q <= 1'b1;
          end
          if (last_beat && !burst_err) begin
            cur_addr  <= cur_addr + (beats_now << 2);
            remaining <= remaining - beats_now;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_reader.sv
// Directed bench for painterengine_gpu_reader. An in-bench AXI slave returns
// rdata equal to the byte address of each beat, so FIFO writes must arrive as
// start, start+4, start+8, ... in order.
module tb_painterengine_gpu_reader;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] length = '0;
  logic        done, error;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] fifo_wdata;
  logic        fifo_wen;
  logic        fifo_full = 1'b0;
  logic [31:0] state;

  painterengine_gpu_reader #(.MAX_BURST(16)) dut (
    .i_wire_clock(clk), .i_wire_resetn(resetn), .i_wire_enable(enable),
    .i_wire_address(address), .i_wire_length(length),
    .o_wire_done(done), .o_wire_error(error),
    .o_wire_araddr(araddr), .o_wire_arlen(arlen), .o_wire_arsize(arsize),
    .o_wire_arburst(arburst), .o_wire_arvalid(arvalid), .i_wire_arready(arready),
    .i_wire_rdata(rdata), .i_wire_rresp(rresp), .i_wire_rlast(rlast),
    .i_wire_rvalid(rvalid), .o_wire_rready(rready),
    .o_wire_fifo_wdata(fifo_wdata), .o_wire_fifo_wen(fifo_wen),
    .i_wire_fifo_full(fifo_full), .o_wire_state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Results of the last run_job call.
  int          n_ar, n_wr, wr_bad, wr_full, rr_bad, end_cyc, first_av, av_seen;
  logic [31:0] ar_addr [0:7];
  logic [7:0]  ar_len  [0:7];
  // Knobs for run_job.
  bit          full_toggle = 1'b0;
  int          resp_err_beat = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Zero-wait slave in lockstep with the DUT. Inputs change at the negedge,
  // outputs are sampled 1 ns later. Ends once done or error is seen.
  task automatic run_job(input logic [31:0] addr, input logic [31:0] len, input int budget);
    int beat, blen, glb;
    bit busy;
    logic [31:0] baddr;
    n_ar = 0; n_wr = 0; wr_bad = 0; wr_full = 0; rr_bad = 0;
    end_cyc = -1; first_av = -1; av_seen = 0;
    beat = 0; blen = 0; glb = 0; busy = 1'b0; baddr = '0;
    @(negedge clk);
    address = addr; length = len; enable = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (done || error) begin
        end_cyc = cyc;
        break;
      end
      arready   = 1'b1;
      rvalid    = busy;
      rdata     = busy ? baddr + 32'(4 * beat) : 32'd0;
      rlast     = busy && (beat == blen);
      rresp     = (busy && glb == resp_err_beat) ? 2'b10 : 2'b00;
      fifo_full = full_toggle ? cyc[0] : 1'b0;
      #1;
      if (arvalid) begin
        av_seen++;
        if (first_av < 0) first_av = cyc;
      end
      if (busy && (rready !== !fifo_full)) rr_bad++;
      if (fifo_wen && fifo_full) wr_full++;
      if (fifo_wen) begin
        if (fifo_wdata !== addr + 32'(4 * n_wr)) wr_bad++;
        n_wr++;
      end
      if (rvalid && rready) begin
        beat++; glb++;
        if (beat > blen) busy = 1'b0;
      end
      if (arvalid && arready) begin
        if (n_ar < 8) begin
          ar_addr[n_ar] = araddr;
          ar_len[n_ar]  = arlen;
        end
        n_ar++;
        busy = 1'b1; beat = 0; blen = int'(arlen); baddr = araddr;
      end
    end
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; fifo_full = 1'b0;
  endtask

  // Status must hold while enable stays high and clear once it drops.
  task automatic finish_job(input string tag, input logic exp_done, input logic exp_err);
    @(negedge clk); #1;
    check({tag, "_done_held"}, 32'(done), 32'(exp_done));
    check({tag, "_err_held"}, 32'(error), 32'(exp_err));
    enable = 1'b0;
    @(negedge clk); #1;
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_idle"}, state, 32'h0);
  endtask

  initial begin
    int wen_cnt, rr_cnt;

    // Reset values.
    #12;
    check("rst_state", state, 32'h0);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_arsize", 32'(arsize), 32'd2);
    check("rst_arburst", 32'(arburst), 32'd1);
    check("rst_araddr", araddr, 32'd0);
    @(negedge clk); resetn = 1'b1;

    // 64 words at 0x1000: four 16-beat bursts.
    run_job(32'h1000, 32'd64, 200);
    check("j64_done", 32'(done), 32'd1);
    check("j64_error", 32'(error), 32'd0);
    check("j64_n_ar", 32'(n_ar), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("j64_araddr", ar_addr[i], 32'h1000 + 32'(i * 64));
      check("j64_arlen", 32'(ar_len[i]), 32'd15);
    end
    check("j64_n_wr", 32'(n_wr), 32'd64);
    check("j64_wr_order", 32'(wr_bad), 32'd0);
    finish_job("j64", 1'b1, 1'b0);

    // Single 16-beat job: arvalid after 2 cycles, done after 20.
    run_job(32'h2000, 32'd16, 100);
    check("j16_first_arvalid", 32'(first_av), 32'd2);
    check("j16_done_latency", 32'(end_cyc), 32'd20);
    check("j16_n_wr", 32'(n_wr), 32'd16);
    finish_job("j16", 1'b1, 1'b0);

    // Burst crossing the 4 KB boundary.
    run_job(32'h1FF0, 32'd8, 100);
    check("j4k_done", 32'(done), 32'd1);
    check("j4k_n_wr", 32'(n_wr), 32'd8);
    check("j4k_wr_order", 32'(wr_bad), 32'd0);
`ifdef PAINTERENGINE_GPU_READER_4K_SPLIT_EN
    check("j4k_n_ar", 32'(n_ar), 32'd2);
    check("j4k_araddr0", ar_addr[0], 32'h1FF0);
    check("j4k_arlen0", 32'(ar_len[0]), 32'd3);
    check("j4k_araddr1", ar_addr[1], 32'h2000);
    check("j4k_arlen1", 32'(ar_len[1]), 32'd3);
`else
    check("j4k_n_ar", 32'(n_ar), 32'd1);
    check("j4k_araddr0", ar_addr[0], 32'h1FF0);
    check("j4k_arlen0", 32'(ar_len[0]), 32'd7);
`endif
    finish_job("j4k", 1'b1, 1'b0);

    // Zero length: done two cycles after enable, no AXI traffic.
    run_job(32'h5000, 32'd0, 20);
    check("len0_latency", 32'(end_cyc), 32'd2);
    check("len0_done", 32'(done), 32'd1);
    check("len0_arvalid_seen", 32'(av_seen), 32'd0);
    finish_job("len0", 1'b1, 1'b0);

    // Misaligned start address.
    run_job(32'h1002, 32'd16, 20);
    check("misal_latency", 32'(end_cyc), 32'd2);
    check("misal_error", 32'(error), 32'd1);
    check("misal_done", 32'(done), 32'd0);
    check("misal_arvalid_seen", 32'(av_seen), 32'd0);
    finish_job("misal", 1'b0, 1'b1);

    // FIFO full toggling every other cycle during a 16-beat burst.
    full_toggle = 1'b1;
    run_job(32'h4000, 32'd16, 200);
    full_toggle = 1'b0;
    check("full_done", 32'(done), 32'd1);
    check("full_n_wr", 32'(n_wr), 32'd16);
    check("full_wr_while_full", 32'(wr_full), 32'd0);
    check("full_rready_mirror", 32'(rr_bad), 32'd0);
    check("full_wr_order", 32'(wr_bad), 32'd0);
    finish_job("full", 1'b1, 1'b0);

    // SLVERR on the third beat of the first burst of a two-burst job.
    resp_err_beat = 2;
    run_job(32'h6000, 32'd32, 200);
    resp_err_beat = -1;
    check("resp_error", 32'(error), 32'd1);
    check("resp_done", 32'(done), 32'd0);
    check("resp_n_ar", 32'(n_ar), 32'd1);
    check("resp_n_wr", 32'(n_wr), 32'd16);
    check("resp_latency", 32'(end_cyc), 32'd20);
    finish_job("resp", 1'b0, 1'b1);

    // Abort while the address is still waiting for arready.
    @(negedge clk);
    address = 32'h3000; length = 32'd16; enable = 1'b1; arready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check("abort_arvalid_up", 32'(arvalid), 32'd1);
    check("abort_state_addr", state, 32'h2);
    enable = 1'b0;
    @(negedge clk); #1;
    check("abort_state", state, 32'h6);
    check("abort_arvalid_hold", 32'(arvalid), 32'd1);
    check("abort_araddr", araddr, 32'h3000);
    check("abort_arlen", 32'(arlen), 32'd15);
    @(negedge clk); #1;
    check("abort_arvalid_hold2", 32'(arvalid), 32'd1);
    arready = 1'b1;
    @(negedge clk); arready = 1'b0; #1;
    check("abort_arvalid_drop", 32'(arvalid), 32'd0);
    wen_cnt = 0; rr_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      rvalid = 1'b1; rdata = 32'(i); rlast = (i == 15);
      #1;
      if (rready !== 1'b1) rr_cnt++;
      if (fifo_wen !== 1'b0) wen_cnt++;
    end
    @(negedge clk); rvalid = 1'b0; rlast = 1'b0; #1;
    check("abort_rready_drain", 32'(rr_cnt), 32'd0);
    check("abort_no_fifo_wen", 32'(wen_cnt), 32'd0);
    check("abort_back_idle", state, 32'h0);

    // Asynchronous reset in the middle of a job.
    @(negedge clk);
    address = 32'h7000; length = 32'd16; enable = 1'b1; arready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    check("rstmid_in_data", state, 32'h3);
    resetn = 1'b0; #1;
    check("rstmid_state", state, 32'h0);
    check("rstmid_rready", 32'(rready), 32'd0);
    check("rstmid_arlen", 32'(arlen), 32'd0);
    @(negedge clk); enable = 1'b0; arready = 1'b0; resetn = 1'b1;
    @(negedge clk); #1;
    check("rstmid_idle_after", state, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
